// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares the single-port label SRAM between the labeling pass (r0)
// and the relabel/merge pass (r1), and runs a full-memory clear sweep on request.
//
// Ports
//   clk                    clock, all state on posedge
//   reset                  asynchronous, active-low
//   clr_start / clr_busy   start pulse for the clear sweep / sweep in progress (registered)
//   rN_req/addr/wen/wdata  requester N command (wen: 0=write, 1=read)
//   rN_gnt                 combinational grant; beat accepted when req&gnt at posedge
//   rN_rvalid / rN_rdata   read data valid the cycle after an accepted read
//   sram_a/d/wen, sram_q   direct connection to the SRAM macro
module sram_port_arbiter #(
    parameter int                AW       = 10,
    parameter int                DW       = 8,
    parameter logic [DW-1:0]     CLR_VAL  = '0,
    parameter int                MAX_HOLD = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_start,
    output logic          clr_busy,
    input  logic          r0_req,
    input  logic [AW-1:0] r0_addr,
    input  logic          r0_wen,
    input  logic [DW-1:0] r0_wdata,
    output logic          r0_gnt,
    output logic          r0_rvalid,
    output logic [DW-1:0] r0_rdata,
    input  logic          r1_req,
    input  logic [AW-1:0] r1_addr,
    input  logic          r1_wen,
    input  logic [DW-1:0] r1_wdata,
    output logic          r1_gnt,
    output logic          r1_rvalid,
    output logic [DW-1:0] r1_rdata,
    output logic [AW-1:0] sram_a,
    output logic [DW-1:0] sram_d,
    output logic          sram_wen,
    input  logic [DW-1:0] sram_q
);
    localparam int HW = $clog2(MAX_HOLD + 1);

    typedef enum logic {ARB, CLEAR} state_t;

    state_t        state, state_nx;
    logic          owner, owner_nx;
    logic [HW-1:0] hold_cnt, hold_nx;
    logic [AW-1:0] clr_cnt, clr_cnt_nx;
    logic          both, sel, any;

    assign r0_rdata = sram_q;
    assign r1_rdata = sram_q;

    always_comb begin
        both = r0_req && r1_req;
        // sel: 0 picks r0, 1 picks r1; the owner keeps the port until its hold budget is spent
        sel = both ? ((hold_cnt < HW'(MAX_HOLD)) ? owner : ~owner) : r1_req;
        // grants are gated by reset so nothing reaches the SRAM while reset is held
        any = reset && (state == ARB) && (r0_req || r1_req);
        r0_gnt = any && !sel;
        r1_gnt = any && sel;
        sram_a = '0;
        sram_d = '0;
        sram_wen = 1'b1;
        if (state == CLEAR) begin
            sram_a = clr_cnt;
            sram_d = CLR_VAL;
            sram_wen = 1'b0;
        end else if (any) begin
            sram_a = sel ? r1_addr : r0_addr;
            sram_d = sel ? r1_wdata : r0_wdata;
            sram_wen = sel ? r1_wen : r0_wen;
        end
        owner_nx = any ? sel : owner;
        hold_nx = !any ? '0 :
                  (sel != owner) ? HW'(1) :
                  (hold_cnt == HW'(MAX_HOLD)) ? hold_cnt : hold_cnt + HW'(1);
        state_nx = state;
        clr_cnt_nx = clr_cnt;
        if (state == ARB) begin
            state_nx = clr_start ? CLEAR : ARB;
        end else begin
            // the counter wraps to zero on the last word, ready for the next sweep
            clr_cnt_nx = clr_cnt + AW'(1);
            state_nx = (&clr_cnt) ? ARB : CLEAR;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ARB;
            owner     <= 1'b0;
            hold_cnt  <= '0;
            clr_cnt   <= '0;
            clr_busy  <= 1'b0;
            r0_rvalid <= 1'b0;
            r1_rvalid <= 1'b0;
        end else begin
            state     <= state_nx;
            owner     <= owner_nx;
            hold_cnt  <= hold_nx;
            clr_cnt   <= clr_cnt_nx;
            clr_busy  <= (state_nx == CLEAR);
            r0_rvalid <= r0_gnt && r0_wen;
            r1_rvalid <= r1_gnt && r1_wen;
        end
    end
endmodule
